// File: rtl/in_port_fifo.sv
// in_port_fifo: input-port FIFO between an external producer and the datapath
// "in" instruction. Words are pushed with a valid/ready handshake and popped by
// rd_en; the popped word is registered onto port_data and held until the next pop.
// Optional feature: define IN_PORT_UNDERFLOW_FLAG_EN to add a sticky 'underflow'
// output that records any pop attempted while the FIFO was empty.
module in_port_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stop,
  input  logic [WIDTH-1:0]       ext_data,
  input  logic                   ext_valid,
  output logic                   ext_ready,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       port_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
`ifdef IN_PORT_UNDERFLOW_FLAG_EN
  ,
  output logic                   underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Storage is deliberately not reset: unread words are discarded by clearing
  // the pointers and count, so stale contents are never observable.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             push_s;
  logic             pop_s;

  // Ready depends on the registered full flag and the live halt input.
  assign ext_ready = !full_q && !stop;

  // Next-state computation for pointers, occupancy, status flags and output word.
  always_comb begin
    push_s   = ext_valid && ext_ready;
    pop_s    = rd_en && !empty_q && !stop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    count_d  = count_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // Only a non-empty FIFO pops, so the same-cycle push word never passes through.
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
      data_d   = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d = rd_ptr_q;
      data_d   = data_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase

    // Status is derived from occupancy, never from pointer equality.
    empty_d = (count_d == CW'(1'b0));
    full_d  = (count_d == CW'(DEPTH));
  end

  // Word storage write on an accepted push.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= ext_data;
    end
  end

  // Control and output registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  assign port_data = data_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;

`ifdef IN_PORT_UNDERFLOW_FLAG_EN
  logic underflow_q, underflow_d;

  // Sticky flag: any pop attempt on an empty, running FIFO sets it until reset.
  always_comb begin
    underflow_d = underflow_q;
    if (rd_en && empty_q && !stop) begin
      underflow_d = 1'b1;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // Underflow register, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
    end
  end

  assign underflow = underflow_q;
`else
  // Default build: no underflow tracking.
`endif

endmodule
